// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle: hazard sources in, stall/flush controls out.
// The pipeline side is the master; the controller is the slave.
interface hazard_stall_ctrl_if #(
  parameter int REGFILE_LEN = 6,
  parameter int CNT_WIDTH   = 32
);
  logic [REGFILE_LEN-1:0] id_rs1;
  logic [REGFILE_LEN-1:0] id_rs2;
  logic                   id_uses_rs1;
  logic                   id_uses_rs2;
  logic [REGFILE_LEN-1:0] ex_rd;
  logic                   ex_mem_read;
  logic                   ex_branch_taken;
  logic                   imem_ready;
  logic                   mem_req;
  logic                   mem_ready;
  logic                   perf_clr;

  logic                   pc_write;
  logic                   stall_if_id;
  logic                   stall_id_ex;
  logic                   stall_ex_mem;
  logic                   stall_mem_wb;
  logic                   flush_if_id;
  logic                   flush_id_ex;
  logic                   mem_timeout;
  logic [1:0]             state;
  logic [CNT_WIDTH-1:0]   stall_count;

  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
           ex_branch_taken, imem_ready, mem_req, mem_ready, perf_clr,
    input  pc_write, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb,
           flush_if_id, flush_id_ex, mem_timeout, state, stall_count
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
           ex_branch_taken, imem_ready, mem_req, mem_ready, perf_clr,
    output pc_write, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb,
           flush_if_id, flush_id_ex, mem_timeout, state, stall_count
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: combinational hazard priority,
// memory-wait FSM with sticky timeout fault, saturating stall-cycle counter.
module hazard_stall_ctrl #(
  parameter int REGFILE_LEN = 6,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                clk,
  input  logic                rst,
  hazard_stall_ctrl_if.slave  bus
);

  localparam int WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0]      WAIT_MAX = WAIT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0]      WAIT_ONE = WAIT_W'(1);
  localparam logic [REGFILE_LEN-1:0] REG_X0   = '0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FAULT    = 2'd2
  } state_e;

  typedef struct packed {
    logic pc_write;
    logic stall_if_id;
    logic stall_id_ex;
    logic stall_ex_mem;
    logic stall_mem_wb;
    logic flush_if_id;
    logic flush_id_ex;
  } ctrl_t;

  localparam ctrl_t CTRL_FREEZE = '{pc_write: 1'b0, stall_if_id: 1'b1, stall_id_ex: 1'b1,
                                    stall_ex_mem: 1'b1, stall_mem_wb: 1'b1,
                                    flush_if_id: 1'b0, flush_id_ex: 1'b0};

  state_e               state_q, state_d;
  logic [WAIT_W-1:0]    wait_cnt_q, wait_cnt_d;
  logic                 mem_timeout_q, mem_timeout_d;
  logic [CNT_WIDTH-1:0] stall_count_q, stall_count_d;

  logic  mem_stall;
  logic  rs1_hit;
  logic  rs2_hit;
  logic  load_use;
  ctrl_t run_ctrl;
  ctrl_t ctrl;

  always_comb begin
    mem_stall = bus.mem_req && !bus.mem_ready;
    rs1_hit   = bus.id_uses_rs1 && (bus.id_rs1 == bus.ex_rd);
    rs2_hit   = bus.id_uses_rs2 && (bus.id_rs2 == bus.ex_rd);
    // x0 is hardwired, so a load targeting it can never create a dependency
    load_use  = bus.ex_mem_read && (bus.ex_rd != REG_X0) && (rs1_hit || rs2_hit);
  end

  // Non-memory hazard resolution; also used on the release cycle of a memory wait
  always_comb begin
    run_ctrl = '0;
    if (bus.ex_branch_taken) begin
      run_ctrl.pc_write    = 1'b1;
      run_ctrl.flush_if_id = 1'b1;
      run_ctrl.flush_id_ex = 1'b1;
    end else if (load_use) begin
      run_ctrl.stall_if_id = 1'b1;
      run_ctrl.flush_id_ex = 1'b1;
    end else if (!bus.imem_ready) begin
      run_ctrl.flush_if_id = 1'b1;
    end else begin
      run_ctrl.pc_write    = 1'b1;
    end
  end

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    ctrl          = '0;
    unique case (state_q)
      RUN: begin
        if (mem_stall) begin
          ctrl       = CTRL_FREEZE;
          state_d    = MEM_WAIT;
          wait_cnt_d = WAIT_ONE;
        end else begin
          ctrl       = run_ctrl;
        end
      end
      MEM_WAIT: begin
        if (!mem_stall) begin
          ctrl       = run_ctrl;
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_MAX) begin
          ctrl          = CTRL_FREEZE;
          state_d       = FAULT;
          mem_timeout_d = 1'b1;
        end else begin
          ctrl       = CTRL_FREEZE;
          wait_cnt_d = wait_cnt_q + WAIT_ONE;
        end
      end
      FAULT: begin
        ctrl          = CTRL_FREEZE;
        mem_timeout_d = 1'b1;
      end
      default: begin
        ctrl       = CTRL_FREEZE;
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase
    if (rst) begin
      ctrl = '0;
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (bus.perf_clr) begin
      stall_count_d = '0;
    end else if (!ctrl.pc_write && (stall_count_q != {CNT_WIDTH{1'b1}})) begin
      stall_count_d = stall_count_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= RUN;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign bus.pc_write     = ctrl.pc_write;
  assign bus.stall_if_id  = ctrl.stall_if_id;
  assign bus.stall_id_ex  = ctrl.stall_id_ex;
  assign bus.stall_ex_mem = ctrl.stall_ex_mem;
  assign bus.stall_mem_wb = ctrl.stall_mem_wb;
  assign bus.flush_if_id  = ctrl.flush_if_id;
  assign bus.flush_id_ex  = ctrl.flush_id_ex;
  assign bus.mem_timeout  = mem_timeout_q;
  assign bus.state        = state_q;
  assign bus.stall_count  = stall_count_q;

endmodule
